led_seq_mc: RTL and testbench

LED_SEQ_MC -- requirements
Module: led_seq_mc

---
 rtl/led_seq_mc.sv | 80 ++++++++
 tb/tb_led_seq_mc.sv | 138 +++++++++++++
 2 files changed

// File: rtl/led_seq_mc.sv
// led_seq_mc: N-channel LED sequencer with OFF/ON/SINGLE/LOOP flash bursts on a shared prescaler tick
module led_seq_mc #(
  parameter int N   = 3,
  parameter int DW  = 20,
  parameter int GAP = 4
) (
  input  logic           clk,
  input  logic           rst,
  output logic [N-1:0]   led,
  input  logic [2*N-1:0] cfg_mode,
  input  logic [4*N-1:0] cfg_cnt,
  input  logic [N-1:0]   go,
  output logic [N-1:0]   rdy
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_FON  = 3'd2;
  localparam logic [2:0] S_FOFF = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [3:0] LAST   = 4'(GAP - 1);
  logic [DW-1:0] pre;
  logic tick;
  assign tick = &pre;
  always_ff @(posedge clk) pre <= rst ? '0 : pre + DW'(1);
  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [2:0] st, nst;
    logic [1:0] md, nmd, mi;
    logic [3:0] cn, ncn, ci, fc, nfc, gc, ngc;
    logic ld, bs, nbs, l, r;
    assign mi  = cfg_mode[2*c +: 2];
    assign ci  = cfg_cnt[4*c +: 4];
    assign ld  = go[c] & r;
    assign nmd = ld ? mi : md;
    assign ncn = ld ? ci : cn;
    assign bs  = (st != S_IDLE) & (md == 2'b10);
    assign nbs = (nst != S_IDLE) & (nmd == 2'b10);
    assign led[c] = l;
    assign rdy[c] = r;
    // a load always beats a coincident tick, so the old state never advances
    always_comb begin
      nst = st;
      nfc = fc;
      ngc = 4'd0;
      if (ld) begin
        nst = mi[1] ? S_WAIT : S_IDLE;
        nfc = mi[1] ? ci : 4'd0;
      end else if (tick) begin
        if (st == S_WAIT || st == S_FOFF) nst = (fc != 4'd0) ? S_FON : S_GAP;
        else if (st == S_FON) begin
          nst = S_FOFF;
          nfc = fc - 4'd1;
        end else if (st == S_GAP) begin
          if (gc == LAST) begin
            nst = ~md[0] ? S_IDLE : (cn != 4'd0) ? S_FON : S_GAP;
            nfc = md[0] ? cn : 4'd0;
          end else ngc = gc + 4'd1;
        end
      end else if (st == S_GAP) ngc = gc;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st <= S_IDLE;
        md <= 2'b00;
        cn <= 4'd0;
        fc <= 4'd0;
        gc <= 4'd0;
        l  <= 1'b0;
        r  <= 1'b1;
      end else begin
        st <= nst;
        md <= nmd;
        cn <= ncn;
        fc <= nfc;
        gc <= ngc;
        l  <= (st == S_FON) | ((st == S_IDLE) & (md == 2'b01));
        r  <= ~(bs | nbs);
      end
    end
  end
endmodule

// File: tb/tb_led_seq_mc.sv
// tb_led_seq_mc: directed checks of led_seq_mc with N=3, DW=3, GAP=2
module tb_led_seq_mc;
  logic clk = 0, rst = 1;
  logic [2:0] led, rdy, go = '0;
  logic [5:0] cfg_mode = '0;
  logic [11:0] cfg_cnt = '0;
  int checks = 0, errors = 0, cyc = 0;
  led_seq_mc #(.N(3), .DW(3), .GAP(2)) dut (
    .clk(clk), .rst(rst), .led(led), .cfg_mode(cfg_mode),
    .cfg_cnt(cfg_cnt), .go(go), .rdy(rdy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic tk();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_rst();
    rst = 1;
    go = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    cyc = 0;
  endtask
  initial begin
    // single burst cnt=2 on ch0, with an ignored second go mid-burst
    do_rst();
    chk("rst_led", led, 0);
    chk("rst_rdy", rdy, 7);
    cfg_mode = 6'b00_00_10;
    cfg_cnt = 12'h002;
    go = 3'b001;
    tk();
    go = '0;
    chk("single_rdy_drop", rdy[0], 0);
    while (cyc < 62) begin
      tk();
      chk("single_led", led[0], int'((cyc >= 9 && cyc <= 16) || (cyc >= 25 && cyc <= 32)));
      chk("single_rdy", rdy[0], int'(cyc >= 57));
      chk("single_others", {led[2:1], rdy[2:1]}, 4'b0011);
      if (cyc == 19) begin
        cfg_mode = 6'b00_00_11;
        cfg_cnt = 12'h005;
        go = 3'b001;
      end else go = '0;
    end
    // loop cnt=1 on ch1: 1,0,0,0 per tick, rdy stays high
    do_rst();
    cfg_mode = 6'b00_11_00;
    cfg_cnt = 12'h010;
    go = 3'b010;
    tk();
    go = '0;
    while (cyc < 140) begin
      tk();
      chk("loop_led", led[1], int'(cyc >= 9 && (cyc - 9) % 32 < 8));
      chk("loop_rdy", rdy, 7);
    end
    // ON then OFF on ch2, two-cycle latency each
    do_rst();
    cfg_mode = 6'b01_00_00;
    go = 3'b100;
    tk();
    go = '0;
    chk("on_lat1", led[2], 0);
    tk();
    chk("on_lat2", led[2], 1);
    repeat (3) tk();
    cfg_mode = 6'b00_00_00;
    go = 3'b100;
    tk();
    go = '0;
    chk("off_lat1", led[2], 1);
    tk();
    chk("off_lat2", led[2], 0);
    // reset mid-FON aborts; go during reset ignored; prescaler restarts
    do_rst();
    cfg_mode = 6'b00_11_10;
    cfg_cnt = 12'h032;
    go = 3'b011;
    tk();
    go = '0;
    while (cyc < 12) tk();
    chk("pre_rst_fon", led[1:0], 3);
    rst = 1;
    cfg_mode = 6'b01_01_01;
    go = 3'b111;
    tk();
    chk("mid_rst_led", led, 0);
    chk("mid_rst_rdy", rdy, 7);
    rst = 0;
    go = '0;
    cyc = 0;
    repeat (3) tk();
    chk("post_rst_led", led, 0);
    chk("post_rst_rdy", rdy, 7);
    while (cyc < 10) tk();
    do_rst();
    cfg_mode = 6'b00_00_10;
    cfg_cnt = 12'h001;
    go = 3'b001;
    tk();
    go = '0;
    while (cyc < 8) tk();
    chk("restart_wait", led[0], 0);
    tk();
    chk("restart_fon", led[0], 1);
    // ON load on the tick that would end FON during loop on ch1
    do_rst();
    cfg_mode = 6'b00_11_00;
    cfg_cnt = 12'h010;
    go = 3'b010;
    tk();
    go = '0;
    while (cyc < 15) tk();
    chk("preempt_fon", led[1], 1);
    cfg_mode = 6'b00_01_00;
    go = 3'b010;
    tk();
    go = '0;
    while (cyc < 48) begin
      tk();
      chk("preempt_on", led[1], 1);
      chk("preempt_rdy", rdy, 7);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
